// File: rtl/instr_trace_buffer_pkg.sv
// rtl/instr_trace_buffer_pkg.sv - shared types and decode tables for the commit-trace buffer
// Contents:
//   trace_class_e  instruction class encoding (NrClasses entries)
//   class_pat_t    mask/match pair tagged with the class it selects
//   ClassPats      ordered pattern table, earlier entries win
//   rec_width()    packed width of a trace record {pc, instr, class, ts}
package instr_trace_buffer_pkg;

  localparam int NrClasses = 14;
  localparam int ClsWidth  = 4;

  typedef enum logic [ClsWidth-1:0] {
    CLS_COMPRESSED = 4'd0,
    CLS_LOAD       = 4'd1,
    CLS_STORE      = 4'd2,
    CLS_BRANCH     = 4'd3,
    CLS_JUMP       = 4'd4,
    CLS_CSR        = 4'd5,
    CLS_SYSTEM     = 4'd6,
    CLS_MULDIV     = 4'd7,
    CLS_SUBFP      = 4'd8,
    CLS_FP         = 4'd9,
    CLS_AMO        = 4'd10,
    CLS_FENCE      = 4'd11,
    CLS_ALU        = 4'd12,
    CLS_OTHER      = 4'd13
  } trace_class_e;

  typedef struct packed {
    logic [31:0]  mask;
    logic [31:0]  match;
    trace_class_e cls;
  } class_pat_t;

  localparam logic [31:0] OpcMask   = 32'h0000_007f;
  localparam logic [31:0] F3Mask    = 32'h0000_707f;
  localparam logic [31:0] F7Mask    = 32'hfe00_707f;
  localparam logic [31:0] FullMask  = 32'hffff_ffff;
  localparam logic [31:0] SfenceMsk = 32'hfe00_7fff;

  localparam int NrPats = 36;

  // Ordered by class priority; the decoder takes the first hit.
  localparam class_pat_t ClassPats [NrPats] = '{
    '{OpcMask,   32'h0000_0003, CLS_LOAD},
    '{OpcMask,   32'h0000_0023, CLS_STORE},
    '{OpcMask,   32'h0000_0063, CLS_BRANCH},
    '{OpcMask,   32'h0000_006f, CLS_JUMP},     // JAL
    '{F3Mask,    32'h0000_0067, CLS_JUMP},     // JALR
    '{F3Mask,    32'h0000_1073, CLS_CSR},      // CSRRW
    '{F3Mask,    32'h0000_2073, CLS_CSR},      // CSRRS
    '{F3Mask,    32'h0000_3073, CLS_CSR},      // CSRRC
    '{F3Mask,    32'h0000_5073, CLS_CSR},      // CSRRWI
    '{F3Mask,    32'h0000_6073, CLS_CSR},      // CSRRSI
    '{F3Mask,    32'h0000_7073, CLS_CSR},      // CSRRCI
    '{FullMask,  32'h0000_0073, CLS_SYSTEM},   // ECALL
    '{FullMask,  32'h0010_0073, CLS_SYSTEM},   // EBREAK
    '{FullMask,  32'h0020_0073, CLS_SYSTEM},   // URET
    '{FullMask,  32'h1020_0073, CLS_SYSTEM},   // SRET
    '{FullMask,  32'h3020_0073, CLS_SYSTEM},   // MRET
    '{FullMask,  32'h1050_0073, CLS_SYSTEM},   // WFI
    '{SfenceMsk, 32'h1200_0073, CLS_SYSTEM},   // SFENCE.VMA
    '{F7Mask & 32'hfe00_007f, 32'h0200_0033, CLS_MULDIV},  // OP,   funct7=0000001
    '{F7Mask & 32'hfe00_007f, 32'h0200_003b, CLS_MULDIV},  // OP32, funct7=0000001
    '{OpcMask,   32'h0000_000b, CLS_SUBFP},    // custom-0 carries the sub-FP8 ops
    '{OpcMask,   32'h0000_0007, CLS_FP},       // LOAD-FP
    '{OpcMask,   32'h0000_0027, CLS_FP},       // STORE-FP
    '{OpcMask,   32'h0000_0053, CLS_FP},       // OP-FP
    '{OpcMask,   32'h0000_0043, CLS_FP},       // FMADD
    '{OpcMask,   32'h0000_0047, CLS_FP},       // FMSUB
    '{OpcMask,   32'h0000_004b, CLS_FP},       // FNMSUB
    '{OpcMask,   32'h0000_004f, CLS_FP},       // FNMADD
    '{OpcMask,   32'h0000_002f, CLS_AMO},
    '{OpcMask,   32'h0000_000f, CLS_FENCE},
    '{OpcMask,   32'h0000_0033, CLS_ALU},      // OP
    '{OpcMask,   32'h0000_0013, CLS_ALU},      // OP-IMM
    '{OpcMask,   32'h0000_003b, CLS_ALU},      // OP32
    '{OpcMask,   32'h0000_001b, CLS_ALU},      // OP-IMM32
    '{OpcMask,   32'h0000_0037, CLS_ALU},      // LUI
    '{OpcMask,   32'h0000_0017, CLS_ALU}       // AUIPC
  };

  function automatic int rec_width(int vlen, int ts_width);
    return vlen + 32 + ClsWidth + ts_width;
  endfunction

endpackage

// File: rtl/instr_trace_buffer_if.sv
// rtl/instr_trace_buffer_if.sv - trace sink handshake between buffer and consumer
// Signals:
//   trace_valid  head record present
//   trace_ready  sink accepts head this cycle
//   trace_rec    packed record {pc, instr, class, ts}
// Modports: master (buffer side), slave (sink side)
interface instr_trace_buffer_if
  import instr_trace_buffer_pkg::*;
#(
  parameter int RecW = rec_width(64, 32)
);
  logic            trace_valid;
  logic            trace_ready;
  logic [RecW-1:0] trace_rec;

  modport master (output trace_valid, output trace_rec, input trace_ready);
  modport slave  (input trace_valid, input trace_rec, output trace_ready);
endinterface

// File: rtl/instr_trace_buffer_trace_class_decode.sv
// rtl/instr_trace_buffer_trace_class_decode.sv - combinational instruction classifier
// Ports:
//   instr_i  in   32-bit raw instruction (compressed forms live in [15:0])
//   class_o  out  trace_class_e of the instruction
module trace_class_decode
  import instr_trace_buffer_pkg::*;
(
  input  logic [31:0]  instr_i,
  output trace_class_e class_o
);

  // Scan from the lowest-priority pattern upward so the highest-priority hit is left standing.
  always_comb begin
    class_o = CLS_OTHER;
    if (instr_i[1:0] != 2'b11) begin
      class_o = CLS_COMPRESSED;
    end else begin
      for (int i = NrPats - 1; i >= 0; i--) begin
        if ((instr_i & ClassPats[i].mask) == ClassPats[i].match) begin
          class_o = ClassPats[i].cls;
        end
      end
    end
  end

endmodule

// File: rtl/instr_trace_buffer.sv
// rtl/instr_trace_buffer.sv - multi-port commit-trace capture FIFO with class filter and counters
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   flush_i           discard FIFO contents (and this cycle's pushes/pop)
//   commit_valid_i    per-port retire strobe
//   commit_instr_i    per-port raw instruction
//   commit_pc_i       per-port retire PC
//   class_en_i        per-class capture enable
//   trace             master side of the trace sink handshake
//   class_cnt_o       per-class retired count (unfiltered), saturating
//   drop_cnt_o        records lost to FIFO full, saturating
module instr_trace_buffer
  import instr_trace_buffer_pkg::*;
#(
  parameter int NrCommitPorts = 2,
  parameter int Depth         = 16,
  parameter int VLEN          = 64,
  parameter int TsWidth       = 32,
  parameter int CntWidth      = 32
)(
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NrCommitPorts-1:0]              commit_valid_i,
  input  logic [NrCommitPorts-1:0][31:0]        commit_instr_i,
  input  logic [NrCommitPorts-1:0][VLEN-1:0]    commit_pc_i,
  input  logic [NrClasses-1:0]                  class_en_i,
  instr_trace_buffer_if.master                  trace,
  output logic [NrClasses-1:0][CntWidth-1:0]    class_cnt_o,
  output logic [CntWidth-1:0]                   drop_cnt_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam int IncW = $clog2(NrCommitPorts + 1);
  localparam int SumW = CntWidth + 1;

  typedef struct packed {
    logic [VLEN-1:0]    pc;
    logic [31:0]        instr;
    trace_class_e       cls;
    logic [TsWidth-1:0] ts;
  } trace_rec_t;

  trace_rec_t         mem [Depth];
  logic [PtrW-1:0]    wr_ptr, rd_ptr;
  logic [CntW-1:0]    count;
  logic [TsWidth-1:0] ts_q;

  trace_class_e       cls [NrCommitPorts];
  logic [NrCommitPorts-1:0] acc;
  logic [PtrW-1:0]    slot [NrCommitPorts];
  logic [CntW-1:0]    free, n_push, n_drop;
  logic               valid, pop;

  logic [NrClasses-1:0][IncW-1:0] cls_inc;
  logic [SumW-1:0]    cls_sum [NrClasses];
  logic [SumW-1:0]    drop_sum;

  for (genvar p = 0; p < NrCommitPorts; p++) begin : g_dec
    trace_class_decode u_dec (
      .instr_i (commit_instr_i[p]),
      .class_o (cls[p])
    );
  end

  assign valid = (count != '0);
  assign pop   = valid & trace.trace_ready & ~flush_i;
  // Space is judged on start-of-cycle occupancy; a pop in the same cycle does not help.
  assign free  = CntW'(Depth) - count;

  assign trace.trace_valid = valid;
  assign trace.trace_rec   = valid ? mem[rd_ptr] : '0;

  // Candidates are packed in port order: each accepted one takes the next slot after wr_ptr.
  always_comb begin
    n_push = '0;
    n_drop = '0;
    acc    = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      slot[p] = wr_ptr + n_push[PtrW-1:0];
      if (commit_valid_i[p] && class_en_i[cls[p]] && !flush_i) begin
        if (n_push < free) begin
          acc[p] = 1'b1;
          n_push = n_push + CntW'(1);
        end else begin
          n_drop = n_drop + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NrClasses; c++) begin
      cls_inc[c] = '0;
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (commit_valid_i[p] && (cls[p] == trace_class_e'(c))) begin
          cls_inc[c] = cls_inc[c] + IncW'(1);
        end
      end
      cls_sum[c] = {1'b0, class_cnt_o[c]} + SumW'(cls_inc[c]);
    end
    drop_sum = {1'b0, drop_cnt_o} + SumW'(n_drop);
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (acc[p]) begin
        mem[slot[p]] <= trace_rec_t'{pc: commit_pc_i[p], instr: commit_instr_i[p],
                                     cls: cls[p], ts: ts_q};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PtrW-1:0];
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      count <= count + n_push - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q        <= '0;
      drop_cnt_o  <= '0;
      class_cnt_o <= '0;
    end else begin
      ts_q       <= ts_q + TsWidth'(1);
      drop_cnt_o <= drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
      for (int c = 0; c < NrClasses; c++) begin
        class_cnt_o[c] <= cls_sum[c][CntWidth] ? '1 : cls_sum[c][CntWidth-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// tb/tb_instr_trace_buffer.sv - randomized and directed bench against a queue-based reference model
module tb_instr_trace_buffer;
  import instr_trace_buffer_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 16;
  localparam int VL    = 64;
  localparam int CW    = 32;
  localparam int RWA   = VL + 32 + 4 + 32;
  localparam int RWB   = VL + 32 + 4 + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ready = 1'b0;
  logic [NP-1:0]           cvalid = '0;
  logic [NP-1:0][31:0]     cinstr = '0;
  logic [NP-1:0][VL-1:0]   cpc = '0;
  logic [NrClasses-1:0]    cen = '1;
  logic [NrClasses-1:0][CW-1:0] cls_cnt_a, cls_cnt_b;
  logic [CW-1:0]           drop_a, drop_b;

  instr_trace_buffer_if #(.RecW(RWA)) if_a ();
  instr_trace_buffer_if #(.RecW(RWB)) if_b ();
  assign if_a.trace_ready = ready;
  assign if_b.trace_ready = ready;

  instr_trace_buffer #(.NrCommitPorts(NP), .Depth(DEPTH), .VLEN(VL), .TsWidth(32), .CntWidth(CW)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .commit_valid_i(cvalid),
    .commit_instr_i(cinstr), .commit_pc_i(cpc), .class_en_i(cen), .trace(if_a),
    .class_cnt_o(cls_cnt_a), .drop_cnt_o(drop_a));

  instr_trace_buffer #(.NrCommitPorts(NP), .Depth(DEPTH), .VLEN(VL), .TsWidth(4), .CntWidth(CW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .commit_valid_i(cvalid),
    .commit_instr_i(cinstr), .commit_pc_i(cpc), .class_en_i(cen), .trace(if_b),
    .class_cnt_o(cls_cnt_b), .drop_cnt_o(drop_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [31:0] ts;
  } mrec_t;

  mrec_t       mq[$];
  longint      m_drop;
  longint      m_cls [NrClasses];
  logic [31:0] cyc;
  int          n_checks = 0;
  int          n_pass = 0;

  localparam longint CntMax = (64'd1 << CW) - 1;

  logic [31:0] pool [20] = '{
    32'h00500093, 32'h0002a303, 32'h00b50463, 32'h0000006f, 32'h00008067,
    32'h34011073, 32'h00000073, 32'h30200073, 32'h10500073, 32'h12000073,
    32'h02b50533, 32'h02b5053b, 32'h0000000b, 32'h0002a007, 32'h00b57553,
    32'h0005a02f, 32'h0ff0000f, 32'h000012b7, 32'h00b50533, 32'h00000505
  };

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference classifier written from the ISA field definitions.
  function automatic int ref_class(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    if (ins[1:0] != 2'b11) return 0;
    case (op)
      7'h03: return 1;
      7'h23: return 2;
      7'h63: return 3;
      7'h6f: return 4;
      7'h67: return (f3 == 3'd0) ? 4 : 13;
      7'h73: begin
        if (f3 != 3'd0 && f3 != 3'd4) return 5;
        if (f3 == 3'd0 && (ins == 32'h00000073 || ins == 32'h00100073 || ins == 32'h00200073 ||
                           ins == 32'h10200073 || ins == 32'h30200073 || ins == 32'h10500073 ||
                           (f7 == 7'b0001001 && ins[11:7] == 5'd0))) return 6;
        return 13;
      end
      7'h33, 7'h3b: return (f7 == 7'b0000001) ? 7 : 12;
      7'h0b: return 8;
      7'h07, 7'h27, 7'h53, 7'h43, 7'h47, 7'h4b, 7'h4f: return 9;
      7'h2f: return 10;
      7'h0f: return 11;
      7'h13, 7'h1b, 7'h37, 7'h17: return 12;
      default: return 13;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    for (int c = 0; c < NrClasses; c++) m_cls[c] = 0;
    cyc = 0;
  endtask

  task automatic compare_all();
    logic [RWA-1:0] ea;
    logic [RWB-1:0] eb;
    logic [NrClasses-1:0][CW-1:0] ec;
    for (int c = 0; c < NrClasses; c++) ec[c] = CW'(m_cls[c]);
    check_eq("valid_a", if_a.trace_valid, mq.size() != 0);
    check_eq("valid_b", if_b.trace_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      ea = {mq[0].pc, mq[0].instr, mq[0].cls, mq[0].ts};
      eb = {mq[0].pc, mq[0].instr, mq[0].cls, mq[0].ts[3:0]};
      check_eq("rec_a", if_a.trace_rec, ea);
      check_eq("rec_b", if_b.trace_rec, eb);
    end
    check_eq("drop_a", drop_a, CW'(m_drop));
    check_eq("drop_b", drop_b, CW'(m_drop));
    check_eq("cls_cnt_a", cls_cnt_a, ec);
    check_eq("cls_cnt_b", cls_cnt_b, ec);
  endtask

  // Apply the current inputs for one clock, advance the model, then compare.
  task automatic step();
    int  free;
    int  nd;
    int  k;
    bit  pop;
    mrec_t r;
    for (int p = 0; p < NP; p++) begin
      if (cvalid[p]) begin
        k = ref_class(cinstr[p]);
        m_cls[k] = (m_cls[k] + 1 > CntMax) ? CntMax : m_cls[k] + 1;
      end
    end
    if (flush) begin
      mq.delete();
    end else begin
      pop  = (mq.size() != 0) && ready;
      free = DEPTH - mq.size();
      nd   = 0;
      if (pop) mq.delete(0);
      for (int p = 0; p < NP; p++) begin
        k = ref_class(cinstr[p]);
        if (cvalid[p] && cen[k]) begin
          if (free > 0) begin
            r.pc = cpc[p];
            r.instr = cinstr[p];
            r.cls = 4'(k);
            r.ts = cyc;
            mq.push_back(r);
            free--;
          end else begin
            nd++;
          end
        end
      end
      m_drop = (m_drop + nd > CntMax) ? CntMax : m_drop + nd;
    end
    cyc = cyc + 32'd1;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_ports(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    cvalid = v;
    cinstr[0] = i0;
    cinstr[1] = i1;
    cpc[0] = {32'h0, $urandom} & 64'hffff_fffe;
    cpc[1] = {32'h0, $urandom} & 64'hffff_fffe;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid_a", if_a.trace_valid, 1'b0);
    check_eq("rst_rec_a", if_a.trace_rec, '0);
    check_eq("rst_drop_a", drop_a, '0);
    check_eq("rst_cls_a", cls_cnt_a, '0);
    check_eq("rst_valid_b", if_b.trace_valid, 1'b0);
    rst_n = 1'b1;

    // 1: single ADDI
    cen = '1;
    ready = 1'b0;
    set_ports(2'b01, 32'h00500093, 32'h0);
    cpc[0] = 64'h8000_0000;
    step();
    check_eq("t1_cls", if_a.trace_rec[35:32], CLS_ALU);
    check_eq("t1_ts", if_a.trace_rec[31:0], 32'd0);
    check_eq("t1_pc", if_a.trace_rec[RWA-1:RWA-64], 64'h8000_0000);
    check_eq("t1_cnt", cls_cnt_a[CLS_ALU], 32'd1);

    // 2: LW and BEQ together, then drain
    set_ports(2'b11, 32'h0002a303, 32'h00b50463);
    step();
    set_ports(2'b00, 32'h0, 32'h0);
    ready = 1'b1;
    step();
    check_eq("t2_head0", if_a.trace_rec[35:32], CLS_LOAD);
    check_eq("t2_ts0", if_a.trace_rec[31:0], 32'd1);
    step();
    check_eq("t2_head1", if_a.trace_rec[35:32], CLS_BRANCH);
    check_eq("t2_ts1", if_a.trace_rec[31:0], 32'd1);
    step();

    // 3: ALU masked off
    cen[CLS_ALU] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_ports(2'b01, 32'h00500093, 32'h0);
      step();
    end
    check_eq("t3_valid", if_a.trace_valid, 1'b0);
    check_eq("t3_alu", cls_cnt_a[CLS_ALU], 32'd11);
    check_eq("t3_drop", drop_a, 32'd0);

    // 4: fill to full, then push while popping at full
    cen = '1;
    ready = 1'b0;
    set_ports(2'b00, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_ports(2'b11, pool[$urandom_range(0, 19)], pool[$urandom_range(0, 19)]);
      step();
    end
    check_eq("t4_drop", drop_a, 32'd2);
    ready = 1'b1;
    set_ports(2'b11, 32'h00500093, 32'h0002a303);
    step();
    check_eq("t4_drop_full", drop_a, 32'd4);
    set_ports(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 30 && mq.size() > 5; i++) step();

    // 5: flush with concurrent push and pop
    flush = 1'b1;
    set_ports(2'b11, 32'h00500093, 32'h0002a303);
    step();
    flush = 1'b0;
    check_eq("t5_valid", if_a.trace_valid, 1'b0);
    check_eq("t5_drop", drop_a, 32'd4);

    // 6: narrow timestamp wrap and compressed class
    set_ports(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 40 && cyc[3:0] != 4'd1; i++) step();
    set_ports(2'b01, {16'($urandom), 16'h0505}, 32'h0);
    step();
    check_eq("t6_ts_b", if_b.trace_rec[3:0], 4'd1);
    check_eq("t6_cls_b", if_b.trace_rec[7:4], CLS_COMPRESSED);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_ports(2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 19)],
                ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 19)]);
      ready = ($urandom_range(0, 3) != 0) ? (i % 64 < 40) : 1'b0;
      flush = ($urandom_range(0, 31) == 0);
      cen = ($urandom_range(0, 3) == 0) ? NrClasses'($urandom) : '1;
      step();
    end
    flush = 1'b0;

    // Asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid_a", if_a.trace_valid, 1'b0);
    check_eq("arst_drop_a", drop_a, '0);
    check_eq("arst_cls_a", cls_cnt_a, '0);
    check_eq("arst_valid_b", if_b.trace_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
